lsu_misalign: RTL and testbench

Load/store unit between the core datapath and `dmem`. Accepts one memory request at a time over a valid/ready handshake. Drives `dmem`'s `we`, `a`, `wd` and `funct3`, and splits misaligned accesses into legal aligned sequences: two word reads for a load that crosses a word boundary, per-byte SB writes for a misaligned store. Returns a registered, sign- or zero-extended load result with a one-cycle `resp_valid` pulse.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/load_align.sv | 30 +++
 rtl/lsu_misalign.sv | 154 +++++++++++++++
 tb/tb_lsu_misalign.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the misalignment-splitting load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size in bytes for a load/store funct3; 0 marks an illegal encoding.
  function automatic logic [2:0] f3_size(input logic [2:0] funct3);
    logic [2:0] size;
    case (funct3)
      F3_B, F3_BU: size = 3'd1;
      F3_H, F3_HU: size = 3'd2;
      F3_W:        size = 3'd4;
      default:     size = 3'd0;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts a byte/half/word from a {hi,lo} word pair at a byte offset and
// sign- or zero-extends it according to the load funct3.
module load_align
  import lsu_pkg::*;
(
  input  logic [63:0] word_pair_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [5:0]  base_s;
  logic [31:0] window_s;

  assign base_s   = {1'b0, offset_i, 3'b000};
  assign window_s = word_pair_i[base_s +: 32];

  // Apply the extension rule selected by funct3.
  always_comb begin
    case (funct3_i)
      F3_B:    data_o = {{24{window_s[7]}}, window_s[7:0]};
      F3_BU:   data_o = {24'd0, window_s[7:0]};
      F3_H:    data_o = {{16{window_s[15]}}, window_s[15:0]};
      F3_HU:   data_o = {16'd0, window_s[15:0]};
      F3_W:    data_o = window_s;
      default: data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_misalign.sv
// Load/store unit: one request at a time, splits word-crossing loads into two
// aligned word reads and misaligned stores into per-byte SB writes.
module lsu_misalign
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rd
);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] addr_q, wdata_q, lo_q, lo_d, rdata_q, rdata_d;
  logic [2:0]  f3_q, size_q;
  logic        we_q, err_q, err_d;

  logic [2:0]  req_size_s, end_s, last_idx_s;
  logic        split_s, mis_s, last_s;
  logic [31:0] word_addr_s, load_data_s, byte_shift_s;
  logic [63:0] pair_s;

  assign req_size_s   = f3_size(req_funct3);
  assign end_s        = {1'b0, addr_q[1:0]} + size_q;
  assign split_s      = !we_q && (end_s > 3'd4);
  assign mis_s        = we_q && (((size_q == 3'd2) && addr_q[0]) ||
                                 ((size_q == 3'd4) && (addr_q[1:0] != 2'd0)));
  assign last_idx_s   = split_s ? 3'd1 : (mis_s ? (size_q - 3'd1) : 3'd0);
  assign last_s       = ({1'b0, idx_q} == last_idx_s);
  assign word_addr_s  = {addr_q[31:2], 2'b00};
  assign byte_shift_s = wdata_q >> {idx_q, 3'b000};
  assign pair_s       = split_s ? {mem_rd, lo_q} : {32'd0, mem_rd};

  load_align u_align (
    .word_pair_i (pair_s),
    .offset_i    (addr_q[1:0]),
    .funct3_i    (f3_q),
    .data_o      (load_data_s)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Next-state sequencing and the memory command for the current ACCESS step.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lo_d       = lo_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    mem_a      = 32'd0;
    mem_wd     = 32'd0;
    mem_funct3 = 3'b000;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d   = 2'd0;
          rdata_d = 32'd0;
          err_d   = (req_size_s == 3'd0);
          state_d = (req_size_s == 3'd0) ? RESP : ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (we_q) begin
          mem_we = 1'b1;
          if (mis_s) begin
            mem_a      = addr_q + {30'd0, idx_q};
            mem_wd     = {24'd0, byte_shift_s[7:0]};
            mem_funct3 = F3_B;
          end else begin
            mem_a      = addr_q;
            mem_wd     = wdata_q;
            mem_funct3 = f3_q;
          end
        end else if (split_s) begin
          mem_a      = (idx_q == 2'd0) ? word_addr_s : (word_addr_s + 32'd4);
          mem_funct3 = F3_W;
          if (idx_q == 2'd0) begin
            lo_d = mem_rd;
          end else begin
            lo_d = lo_q;
          end
        end else begin
          mem_a      = addr_q;
          mem_funct3 = f3_q;
        end
        if (last_s) begin
          state_d = RESP;
          rdata_d = we_q ? 32'd0 : load_data_s;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, step index, captured low word and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      lo_q    <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request fields are captured only on the accepting handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      f3_q    <= 3'b000;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
    end else if (req_valid && req_ready) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      f3_q    <= req_funct3;
      we_q    <= req_we;
      size_q  <= req_size_s;
    end
  end

endmodule

// File: tb/tb_lsu_misalign.sv
// Directed bench for lsu_misalign with a small behavioural dmem model.
module tb_lsu_misalign;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic [2:0]  mem_funct3;

  logic [31:0] mem [0:15];
  logic        restore = 1'b0;

  int          n_chk = 0;
  int          n_fail = 0;
  int          lat;
  logic [31:0] a_log [0:7];
  logic        we_log [0:7];
  logic [2:0]  f3_log [0:7];
  logic        seen;

  always #5 clk = ~clk;

  lsu_misalign dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_funct3 (mem_funct3),
    .mem_rd     (mem_rd)
  );

  assign mem_rd = mem[mem_a[5:2]];

  // dmem: posedge write by funct3 size, or a backdoor reload of the preload image.
  always @(posedge clk) begin
    if (restore) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
      mem[0] <= 32'h44332211;
      mem[1] <= 32'h88776655;
    end else if (mem_we) begin
      case (mem_funct3[1:0])
        2'b00:   mem[mem_a[5:2]][{mem_a[1:0], 3'b000} +: 8] <= mem_wd[7:0];
        2'b01:   mem[mem_a[5:2]][{mem_a[1], 4'b0000} +: 16] <= mem_wd[15:0];
        default: mem[mem_a[5:2]] <= mem_wd;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic reload();
    @(negedge clk); restore = 1'b1;
    @(negedge clk); restore = 1'b0;
  endtask

  // Present a request and return just after the accepting edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit hold);
    int n;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  // Log each cycle's memory command until resp_valid, bounded; lat=99 on timeout.
  task automatic collect();
    lat = 99;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i < 8) begin a_log[i] = mem_a; we_log[i] = mem_we; f3_log[i] = mem_funct3; end
      if (resp_valid) begin lat = i + 1; break; end
    end
  endtask

  initial begin
    restore = 1'b1;
    repeat (2) @(negedge clk);
    restore = 1'b0;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    @(negedge clk); reset = 1'b0;

    // 1. aligned loads
    issue(1'b0, 3'b010, 32'h0, 32'h0, 1'b0); collect();
    chk("lw0_lat", lat, 32'd2);
    chk("lw0_data", resp_rdata, 32'h44332211);
    chk("lw0_err", {31'd0, resp_err}, 32'd0);
    issue(1'b0, 3'b100, 32'h1, 32'h0, 1'b0); collect();
    chk("lbu1_data", resp_rdata, 32'h00000022);

    // 2. split and signed loads
    issue(1'b0, 3'b001, 32'h3, 32'h0, 1'b0); collect();
    chk("lh3_lat", lat, 32'd3);
    chk("lh3_a0", a_log[0], 32'h0);
    chk("lh3_a1", a_log[1], 32'h4);
    chk("lh3_we", {31'd0, we_log[0] | we_log[1]}, 32'd0);
    chk("lh3_data", resp_rdata, 32'h00005544);
    issue(1'b0, 3'b000, 32'h7, 32'h0, 1'b0); collect();
    chk("lb7_data", resp_rdata, 32'hFFFFFF88);
    issue(1'b0, 3'b100, 32'h7, 32'h0, 1'b0); collect();
    chk("lbu7_data", resp_rdata, 32'h00000088);

    // 3. misaligned word store
    issue(1'b1, 3'b010, 32'h2, 32'hAABBCCDD, 1'b0); collect();
    chk("sw2_lat", lat, 32'd5);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sw2_a%0d", i), a_log[i], 32'd2 + 32'(i));
      chk($sformatf("sw2_we%0d", i), {31'd0, we_log[i]}, 32'd1);
      chk($sformatf("sw2_f3_%0d", i), {29'd0, f3_log[i]}, 32'd0);
    end
    chk("sw2_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    chk("sw2_word0", mem[0], 32'hCCDD2211);
    chk("sw2_word1", mem[1], 32'h8877AABB);

    // 4. reset during the misaligned store, after two bytes committed
    reload();
    issue(1'b1, 3'b010, 32'h2, 32'hAABBCCDD, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #2;
    chk("mid_we_before", {31'd0, mem_we}, 32'd1);
    reset = 1'b1; #1;
    chk("mid_we_async", {31'd0, mem_we}, 32'd0);
    chk("mid_ready_rst", {31'd0, req_ready}, 32'd1);
    @(negedge clk); @(negedge clk); reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | resp_valid;
    end
    chk("mid_no_resp", {31'd0, seen}, 32'd0);
    chk("mid_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_word0", mem[0], 32'hCCDD2211);
    chk("mid_word1", mem[1], 32'h88776655);

    // 5. illegal funct3 store
    issue(1'b1, 3'b011, 32'h0, 32'h12345678, 1'b0); collect();
    chk("ill_lat", lat, 32'd1);
    chk("ill_we", {31'd0, we_log[0]}, 32'd0);
    chk("ill_err", {31'd0, resp_err}, 32'd1);
    chk("ill_rdata", resp_rdata, 32'd0);
    chk("ill_word0", mem[0], 32'hCCDD2211);

    // 6. back-to-back with req_valid held
    issue(1'b1, 3'b001, 32'h0, 32'h0000BEEF, 1'b1); collect();
    chk("b2b_sh_lat", lat, 32'd2);
    chk("b2b_sh_err", {31'd0, resp_err}, 32'd0);
    req_we = 1'b0; req_funct3 = 3'b101; req_addr = 32'h0; req_wdata = 32'd0;
    chk("b2b_ready_resp", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("b2b_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1; req_valid = 1'b0;
    collect();
    chk("b2b_lhu_lat", lat, 32'd2);
    chk("b2b_lhu_data", resp_rdata, 32'h0000BEEF);
    chk("b2b_word0", mem[0], 32'hCCDDBEEF);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
